// File: rtl/freq_meas_ctrl.sv
// Frequency meter gate sequencer: hysteretic pulse from ADC samples, gated 6-digit
// BCD edge counter, result latch and decimal auto-ranging of the gate length.
module freq_meas_ctrl #(
   parameter int GATE_CYC    = 100000000,
   parameter int HOLDOFF_CYC = 1000,
   parameter int FULL_SCALE  = 999999,
   parameter int THRESH_HI   = 136,
   parameter int THRESH_LO   = 120
) (
   input  logic        clk100,
   input  logic        rst_n,
   input  logic        run_en,
   input  logic        auto_en,
   input  logic [1:0]  range_sel,
   input  logic [7:0]  data_in,
   output logic [23:0] bcd_out,
   output logic [1:0]  range_out,
   output logic        ovf_out,
   output logic        result_valid,
   output logic        gate_active
);
   localparam logic [26:0] GATE_LEN0 = 27'(GATE_CYC);
   localparam logic [26:0] GATE_LEN1 = 27'(GATE_CYC / 10);
   localparam logic [26:0] GATE_LEN2 = 27'(GATE_CYC / 100);
   localparam logic [26:0] HOLD_LEN  = 27'(HOLDOFF_CYC);
   localparam logic [19:0] FS_BIN    = 20'(FULL_SCALE);
   localparam logic [19:0] LOW_BIN   = 20'((FULL_SCALE + 1) / 20);
   localparam logic [7:0]  TH_HI     = 8'(THRESH_HI);
   localparam logic [7:0]  TH_LO     = 8'(THRESH_LO);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_GATE    = 3'd2,
      S_LATCH   = 3'd3,
      S_HOLDOFF = 3'd4
   } state_t;

   state_t      r_state;
   logic [26:0] r_timer;
   logic        r_pulse;
   logic        r_pulse_d1;
   logic [23:0] r_bcd;
   logic [19:0] r_bin;
   logic        r_ovf;
   logic [1:0]  r_range;
   logic [1:0]  r_next_range;
   logic        r_auto_used;
   logic [23:0] r_bcd_out;
   logic [1:0]  r_range_out;
   logic        r_ovf_out;
   logic        r_valid;
   logic        r_gate_active;

   logic        w_edge;
   logic [1:0]  w_man_range;
   logic [1:0]  w_sel_range;
   logic [26:0] w_gate_len;

   function automatic logic [23:0] bcd_inc(input logic [23:0] v);
      logic [23:0] res;
      logic        carry;
      res   = v;
      carry = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (carry) begin
            if (res[i*4 +: 4] == 4'd9) begin
               res[i*4 +: 4] = 4'd0;
               carry         = 1'b1;
            end else begin
               res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
               carry         = 1'b0;
            end
         end else begin
            carry = 1'b0;
         end
      end
      return res;
   endfunction

   assign w_edge = r_pulse & ~r_pulse_d1;

   // Range chosen for the next gate and the matching gate length
   always_comb begin
      w_man_range = (range_sel == 2'd3) ? 2'd2 : range_sel;
      w_sel_range = auto_en ? r_next_range : w_man_range;
      case (w_sel_range)
         2'd0:    w_gate_len = GATE_LEN0;
         2'd1:    w_gate_len = GATE_LEN1;
         default: w_gate_len = GATE_LEN2;
      endcase
   end

   // Hysteretic comparator and its one-cycle delay for rising-edge detection
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         r_pulse    <= 1'b0;
         r_pulse_d1 <= 1'b0;
      end else begin
         if (data_in >= TH_HI) begin
            r_pulse <= 1'b1;
         end else if (data_in < TH_LO) begin
            r_pulse <= 1'b0;
         end else begin
            r_pulse <= r_pulse;
         end
         r_pulse_d1 <= r_pulse;
      end
   end

   // Gated edge counter: BCD digits for display, binary copy for range decisions
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         r_bcd <= 24'd0;
         r_bin <= 20'd0;
         r_ovf <= 1'b0;
      end else if (r_state == S_CLEAR) begin
         r_bcd <= 24'd0;
         r_bin <= 20'd0;
         r_ovf <= 1'b0;
      end else if ((r_state == S_GATE) && w_edge) begin
         if (r_bin == FS_BIN) begin
            r_ovf <= 1'b1;
         end else begin
            r_bin <= r_bin + 20'd1;
            r_bcd <= bcd_inc(r_bcd);
         end
      end else begin
         r_bcd <= r_bcd;
         r_bin <= r_bin;
         r_ovf <= r_ovf;
      end
   end

   // Measurement sequencer with registered result and gate outputs
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_timer       <= 27'd0;
         r_range       <= 2'd0;
         r_next_range  <= 2'd0;
         r_auto_used   <= 1'b0;
         r_bcd_out     <= 24'd0;
         r_range_out   <= 2'd0;
         r_ovf_out     <= 1'b0;
         r_valid       <= 1'b0;
         r_gate_active <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_gate_active <= 1'b0;
               if (run_en) begin
                  r_state <= S_CLEAR;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CLEAR: begin
               if (!run_en) begin
                  r_state <= S_IDLE;
               end else begin
                  r_range       <= w_sel_range;
                  r_auto_used   <= auto_en;
                  r_timer       <= w_gate_len;
                  r_gate_active <= 1'b1;
                  r_state       <= S_GATE;
               end
            end
            S_GATE: begin
               if (!run_en) begin
                  r_gate_active <= 1'b0;
                  r_state       <= S_IDLE;
               end else if (r_timer <= 27'd1) begin
                  r_gate_active <= 1'b0;
                  r_state       <= S_LATCH;
               end else begin
                  r_timer <= r_timer - 27'd1;
               end
            end
            S_LATCH: begin
               r_bcd_out   <= r_bcd;
               r_range_out <= r_range;
               r_ovf_out   <= r_ovf;
               r_valid     <= 1'b1;
               // Manual measurements leave the auto-range history untouched
               if (r_auto_used) begin
                  if (r_ovf && (r_range < 2'd2)) begin
                     r_next_range <= r_range + 2'd1;
                  end else if (!r_ovf && (r_range > 2'd0) && (r_bin < LOW_BIN)) begin
                     r_next_range <= r_range - 2'd1;
                  end else begin
                     r_next_range <= r_next_range;
                  end
               end else begin
                  r_next_range <= r_next_range;
               end
               r_timer <= HOLD_LEN;
               r_state <= S_HOLDOFF;
            end
            S_HOLDOFF: begin
               if (r_timer <= 27'd1) begin
                  r_state <= run_en ? S_CLEAR : S_IDLE;
               end else begin
                  r_timer <= r_timer - 27'd1;
               end
            end
            default: begin
               r_gate_active <= 1'b0;
               r_state       <= S_IDLE;
            end
         endcase
      end
   end

   assign bcd_out      = r_bcd_out;
   assign range_out    = r_range_out;
   assign ovf_out      = r_ovf_out;
   assign result_valid = r_valid;
   assign gate_active  = r_gate_active;

endmodule
